// File: rtl/gpio_v2_pkg.sv
// rtl/gpio_v2_pkg.sv - register map and slot FSM types for gpio_v2
package gpio_v2_pkg;

    localparam logic [7:0] OUT_DATA_ADDR   = 8'h00;
    localparam logic [7:0] OUT_SET_ADDR    = 8'h04;
    localparam logic [7:0] OUT_CLR_ADDR    = 8'h08;
    localparam logic [7:0] IN_DATA_ADDR    = 8'h0C;
    localparam logic [7:0] RISE_EN_ADDR    = 8'h10;
    localparam logic [7:0] FALL_EN_ADDR    = 8'h14;
    localparam logic [7:0] IRQ_STATUS_ADDR = 8'h18;
    localparam logic [7:0] IRQ_MASK_ADDR   = 8'h1C;
    localparam logic [7:0] DB_CFG_ADDR     = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } slot_state_t;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } access_t;

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - input synchroniser, shared-prescaler debouncer and edge history
module gpio_debounce #(
    parameter int WIDTH    = 9,
    parameter int DB_CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DB_CNT_W-1:0] db_cfg,
    input  logic                restart,
    input  logic [WIDTH-1:0]    raw,
    output logic [WIDTH-1:0]    deb,
    output logic [WIDTH-1:0]    deb_q
);

    logic [WIDTH-1:0]    meta;
    logic [WIDTH-1:0]    sync;
    logic [WIDTH-1:0]    smp;
    logic [DB_CNT_W-1:0] cnt;
    logic                tick;

    assign tick = !restart && (cnt == db_cfg);

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= '0;
            sync  <= '0;
            smp   <= '0;
            deb   <= '0;
            deb_q <= '0;
            cnt   <= '0;
        end else begin
            meta  <= raw;
            sync  <= meta;
            deb_q <= deb;
            if (restart || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DB_CNT_W'(1);
            end
            if (db_cfg == '0) begin
                deb <= sync;
            end else if (tick) begin
                // a bit follows sync only when two consecutive ticks agree
                smp <= sync;
                deb <= (sync & ~(sync ^ smp)) | (deb & (sync ^ smp));
            end
        end
    end

endmodule

// File: rtl/gpio_v2.sv
// rtl/gpio_v2.sv - MMIO slot GPIO: register file, slot FSM, edge-triggered sticky interrupt
module gpio_v2
    import gpio_v2_pkg::*;
#(
    parameter int NUM_INPUT  = 9,
    parameter int NUM_OUTPUT = 4,
    parameter int DB_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chip_select,
    input  logic                  read,
    input  logic                  write,
    input  logic                  transaction_completed,
    input  logic [7:0]            addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data,
    output logic                  wr_done,
    output logic                  rd_done,
    output logic                  idle,
    output logic                  slave_error,
    output logic                  decode_error,
    input  logic [NUM_INPUT-1:0]  in_ports,
    output logic [NUM_OUTPUT-1:0] out_ports,
    output logic                  irq
);

    slot_state_t           state;
    access_t               acc;
    logic [7:0]            addr_q;
    logic [31:0]           wd;
    logic [NUM_OUTPUT-1:0] out_r;
    logic [NUM_INPUT-1:0]  rise_en, fall_en, status, mask;
    logic [NUM_INPUT-1:0]  deb, deb_q, hw_set, w1c;
    logic [DB_CNT_W-1:0]   db_cfg;
    logic                  is_wr, dec_err, sl_err, commit, db_restart;
    logic [31:0]           rd_val;
    logic                  unused_wd;

    gpio_debounce #(
        .WIDTH    (NUM_INPUT),
        .DB_CNT_W (DB_CNT_W)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .db_cfg  (db_cfg),
        .restart (db_restart),
        .raw     (in_ports),
        .deb     (deb),
        .deb_q   (deb_q)
    );

    assign is_wr     = (acc == ACC_WRITE);
    assign idle      = (state == ST_IDLE);
    assign out_ports = out_r;
    assign unused_wd = ^wd;

    always_comb begin
        dec_err = 1'b0;
        sl_err  = 1'b0;
        rd_val  = '0;
        if (addr_q[1:0] != 2'b00) begin
            dec_err = 1'b1;
        end else begin
            case (addr_q)
                OUT_DATA_ADDR:   rd_val = 32'(out_r);
                OUT_SET_ADDR,
                OUT_CLR_ADDR:    sl_err = !is_wr;
                IN_DATA_ADDR: begin
                    sl_err = is_wr;
                    rd_val = 32'(deb);
                end
                RISE_EN_ADDR:    rd_val = 32'(rise_en);
                FALL_EN_ADDR:    rd_val = 32'(fall_en);
                IRQ_STATUS_ADDR: rd_val = 32'(status);
                IRQ_MASK_ADDR:   rd_val = 32'(mask);
                DB_CFG_ADDR:     rd_val = 32'(db_cfg);
                default:         dec_err = 1'b1;
            endcase
        end
    end

    assign commit     = (state == ST_ACTIVE) && is_wr && !sl_err && !dec_err;
    assign db_restart = commit && (addr_q == DB_CFG_ADDR);
    assign w1c        = (commit && addr_q == IRQ_STATUS_ADDR) ? wd[NUM_INPUT-1:0] : '0;
    assign hw_set     = (deb & ~deb_q & rise_en) | (~deb & deb_q & fall_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            acc          <= ACC_READ;
            addr_q       <= '0;
            wd           <= '0;
            out_r        <= '0;
            rise_en      <= '0;
            fall_en      <= '0;
            status       <= '0;
            mask         <= '0;
            db_cfg       <= '0;
            irq          <= 1'b0;
            rd_data      <= '0;
            wr_done      <= 1'b0;
            rd_done      <= 1'b0;
            slave_error  <= 1'b0;
            decode_error <= 1'b0;
        end else begin
            // hardware set is OR-ed after the clear so a coincident edge survives W1C
            status <= (status & ~w1c) | hw_set;
            irq    <= |(status & mask);
            case (state)
                ST_IDLE: begin
                    if (chip_select && (read || write)) begin
                        acc    <= write ? ACC_WRITE : ACC_READ;
                        addr_q <= addr;
                        wd     <= wr_data;
                        state  <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (commit) begin
                        case (addr_q)
                            OUT_DATA_ADDR: out_r   <= wd[NUM_OUTPUT-1:0];
                            OUT_SET_ADDR:  out_r   <= out_r | wd[NUM_OUTPUT-1:0];
                            OUT_CLR_ADDR:  out_r   <= out_r & ~wd[NUM_OUTPUT-1:0];
                            RISE_EN_ADDR:  rise_en <= wd[NUM_INPUT-1:0];
                            FALL_EN_ADDR:  fall_en <= wd[NUM_INPUT-1:0];
                            IRQ_MASK_ADDR: mask    <= wd[NUM_INPUT-1:0];
                            DB_CFG_ADDR:   db_cfg  <= wd[DB_CNT_W-1:0];
                            default:       ;
                        endcase
                    end
                    rd_data      <= (is_wr || sl_err || dec_err) ? '0 : rd_val;
                    wr_done      <= is_wr;
                    rd_done      <= !is_wr;
                    slave_error  <= sl_err;
                    decode_error <= dec_err;
                    state        <= ST_DONE;
                end
                ST_DONE: begin
                    if (transaction_completed) begin
                        rd_data      <= '0;
                        wr_done      <= 1'b0;
                        rd_done      <= 1'b0;
                        slave_error  <= 1'b0;
                        decode_error <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_v2.sv
// tb/tb_gpio_v2.sv - scoreboard bench for gpio_v2 against a register-level reference model
module tb_gpio_v2;

    localparam int NI = 9;
    localparam int NO = 4;
    localparam logic [31:0] IMASK = 32'h1FF;
    localparam logic [31:0] OMASK = 32'hF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          chip_select = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic          transaction_completed = 1'b0;
    logic [7:0]    addr = '0;
    logic [31:0]   wr_data = '0;
    logic [31:0]   rd_data;
    logic          wr_done, rd_done, idle, slave_error, decode_error, irq;
    logic [NI-1:0] in_ports = '0;
    logic [NO-1:0] out_ports;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          is_wr;
        logic [31:0] data;
        bit          serr;
        bit          derr;
        logic [3:0]  out;
    } exp_t;

    exp_t exp_q[$];

    logic [31:0] m_out, m_rise, m_fall, m_status, m_mask, m_dbcfg, m_in;

    gpio_v2 #(
        .NUM_INPUT  (NI),
        .NUM_OUTPUT (NO),
        .DB_CNT_W   (16)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .chip_select           (chip_select),
        .read                  (read),
        .write                 (write),
        .transaction_completed (transaction_completed),
        .addr                  (addr),
        .wr_data               (wr_data),
        .rd_data               (rd_data),
        .wr_done               (wr_done),
        .rd_done               (rd_done),
        .idle                  (idle),
        .slave_error           (slave_error),
        .decode_error          (decode_error),
        .in_ports              (in_ports),
        .out_ports             (out_ports),
        .irq                   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_rise = 0; m_fall = 0; m_status = 0; m_mask = 0; m_dbcfg = 0; m_in = 0;
    endtask

    // Register-level behaviour: legality by access type, then the register's effect
    function automatic void model_access(input bit wr, input logic [7:0] a,
                                         input logic [31:0] d, output exp_t e);
        int idx;
        e.is_wr = wr;
        e.data  = 0;
        e.serr  = 0;
        e.derr  = 0;
        idx     = int'(a) / 4;
        if (a[1:0] != 2'b00 || a > 8'h20) begin
            e.derr = 1;
        end else if ((wr && idx == 3) || (!wr && (idx == 1 || idx == 2))) begin
            e.serr = 1;
        end else if (wr) begin
            case (idx)
                0: m_out    = d & OMASK;
                1: m_out    = (m_out | d) & OMASK;
                2: m_out    = m_out & ~d;
                4: m_rise   = d & IMASK;
                5: m_fall   = d & IMASK;
                6: m_status = m_status & ~d;
                7: m_mask   = d & IMASK;
                8: m_dbcfg  = d & 32'hFFFF;
                default: ;
            endcase
        end else begin
            case (idx)
                0: e.data = m_out;
                3: e.data = m_in;
                4: e.data = m_rise;
                5: e.data = m_fall;
                6: e.data = m_status;
                7: e.data = m_mask;
                8: e.data = m_dbcfg;
                default: ;
            endcase
        end
        e.out = m_out[3:0];
    endfunction

    function automatic void model_edges(input logic [31:0] v);
        logic [31:0] rise, fall;
        rise     = v & ~m_in & IMASK;
        fall     = ~v & m_in & IMASK;
        m_status = m_status | (rise & m_rise) | (fall & m_fall);
        m_in     = v & IMASK;
    endfunction

    task automatic chk_irq(input string name);
        check(name, 32'(irq), 32'(|(m_status & m_mask)));
    endtask

    task automatic settle();
        repeat (3 * (int'(m_dbcfg) + 1) + 8) @(negedge clk);
    endtask

    task automatic set_inputs(input logic [31:0] v);
        in_ports = v[NI-1:0];
        settle();
        model_edges(v);
        chk_irq("irq_after_edge");
    endtask

    // Issued from a negedge; returns on the negedge after the slot is back in IDLE
    task automatic bus(input bit wr, input logic [7:0] a, input logic [31:0] d, input bit both);
        exp_t e;
        int   k;
        model_access(wr, a, d, e);
        exp_q.push_back(e);
        chip_select = 1'b1;
        write       = wr;
        read        = !wr || both;
        addr        = a;
        wr_data     = d;
        @(negedge clk);
        chip_select = 1'b0;
        write       = 1'b0;
        read        = 1'b0;
        k = 1;
        while (!(wr_done || rd_done) && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("done_latency", 32'(k), 32'd2);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        transaction_completed = 1'b1;
        @(negedge clk);
        transaction_completed = 1'b0;
        check("done_released", 32'(wr_done || rd_done), 32'd0);
        check("idle_after_txn", 32'(idle), 32'd1);
    endtask

    initial begin : monitor
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if ((wr_done || rd_done) && !prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: wr_done=%0b rd_done=%0b with nothing outstanding",
                             wr_done, rd_done);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_done", 32'(wr_done), 32'(e.is_wr));
                    check("rd_done", 32'(rd_done), 32'(!e.is_wr));
                    check("rd_data", rd_data, e.data);
                    check("slave_error", 32'(slave_error), 32'(e.serr));
                    check("decode_error", 32'(decode_error), 32'(e.derr));
                    check("out_ports", 32'(out_ports), 32'(e.out));
                end
            end
            prev = wr_done || rd_done;
        end
    end

    initial begin : stimulus
        logic [7:0]  a;
        logic [31:0] d;
        bit          wr;
        int          r;

        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_idle", 32'(idle), 32'd1);
        check("reset_out", 32'(out_ports), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_done", 32'({wr_done, rd_done, slave_error, decode_error}), 32'd0);

        // output register, atomic set and clear
        bus(1, 8'h00, 32'hA, 0);
        bus(1, 8'h04, 32'h5, 0);
        bus(1, 8'h08, 32'h3, 0);
        check("out_after_clr", 32'(out_ports), 32'hC);

        // illegal and unmapped accesses
        bus(0, 8'h04, 32'h0, 0);
        bus(1, 8'h0C, 32'hFFFF_FFFF, 0);
        bus(0, 8'h40, 32'h0, 0);
        bus(1, 8'h02, 32'hFFFF_FFFF, 1);
        check("out_unchanged", 32'(out_ports), 32'hC);

        // debounce bypass, then glitch rejection with DB_CFG=3
        set_inputs(32'h1FF);
        bus(0, 8'h0C, 0, 0);
        set_inputs(32'h1FE);
        bus(1, 8'h20, 32'd3, 0);
        repeat (4) begin
            in_ports[0] = 1'b1;
            repeat (2) @(negedge clk);
            in_ports[0] = 1'b0;
            repeat (6) @(negedge clk);
        end
        bus(0, 8'h0C, 0, 0);
        in_ports[0] = 1'b1;
        repeat (12) @(negedge clk);
        model_edges(32'h1FF);
        bus(0, 8'h0C, 0, 0);

        // rising-edge interrupt and W1C
        bus(1, 8'h20, 32'd0, 0);
        set_inputs(32'h1FE);
        bus(1, 8'h10, 32'h1, 0);
        bus(1, 8'h1C, 32'h1, 0);
        set_inputs(32'h1FF);
        bus(0, 8'h18, 0, 0);
        check("irq_on_rise", 32'(irq), 32'd1);
        bus(1, 8'h18, 32'h1, 0);
        check("irq_after_w1c", 32'(irq), 32'd0);

        // rising edge lands on the same clock as the W1C commit
        set_inputs(32'h1FE);
        in_ports = 9'h1FF;
        repeat (2) @(negedge clk);
        bus(1, 8'h18, 32'h1, 0);
        model_edges(32'h1FF);
        bus(0, 8'h18, 0, 0);
        chk_irq("irq_w1c_collision");

        // falling-edge interrupt, masked then unmasked
        bus(1, 8'h18, IMASK, 0);
        bus(1, 8'h14, 32'h2, 0);
        bus(1, 8'h1C, 32'h0, 0);
        set_inputs(32'h1FD);
        bus(0, 8'h18, 0, 0);
        check("irq_masked", 32'(irq), 32'd0);
        bus(1, 8'h1C, 32'h2, 0);
        check("irq_unmasked", 32'(irq), 32'd1);

        // randomized traffic against the reference model
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 11);
            if (r <= 9) a = 8'(r * 4);
            else if (r == 10) a = 8'h40 + 8'($urandom_range(0, 15) * 4);
            else a = 8'($urandom_range(0, 8) * 4) | 8'($urandom_range(1, 3));
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            if (a == 8'h20 && wr) d = d & 32'h3;
            bus(wr, a, d, 1'($urandom_range(0, 1)));
            chk_irq("irq_random");
            if ($urandom_range(0, 3) == 0) set_inputs($urandom & IMASK);
        end

        // reset while a write to OUT_DATA sits in ACTIVE
        bus(1, 8'h00, 32'hF, 0);
        chip_select = 1'b1;
        write       = 1'b1;
        addr        = 8'h00;
        wr_data     = 32'h5;
        @(negedge clk);
        chip_select = 1'b0;
        write       = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_idle", 32'(idle), 32'd1);
        check("midrst_out", 32'(out_ports), 32'd0);
        check("midrst_done", 32'({wr_done, rd_done, slave_error, decode_error}), 32'd0);
        model_reset();
        settle();
        model_edges(32'(in_ports));
        bus(0, 8'h00, 0, 0);
        check("midrst_out_final", 32'(out_ports), 32'd0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gpio_v2.md
Name: gpio_v2

Overview:
Parametrised successor to the fixed 9-in/4-out GPIO slot peripheral on the MMIO bus. Provides a word-addressed register map for NUM_OUTPUT output bits (with atomic set/clear) and NUM_INPUT input bits. Inputs pass through a 2-flop synchroniser and a programmable debouncer. Per-bit rising/falling edge detection feeds a sticky, maskable interrupt line.

Parameters:
NUM_INPUT, 9, input channel count (1..32)
NUM_OUTPUT, 4, output channel count (1..32)
DB_CNT_W, 16, debounce prescaler width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
chip_select  in  1  slot select
read  in  1  read request
write  in  1  write request; write has priority if both are high
transaction_completed  in  1  master acknowledge; releases DONE
addr  in  8  byte address; word aligned
wr_data  in  32  write data
rd_data  out  32  read data (registered)
wr_done  out  1  write complete
rd_done  out  1  read complete
idle  out  1  high when FSM is in IDLE
slave_error  out  1  illegal access to a mapped register
decode_error  out  1  unmapped address
in_ports  in  NUM_INPUT  raw asynchronous inputs
out_ports  out  NUM_OUTPUT  output register
irq  out  1  level interrupt = |(IRQ_STATUS & IRQ_MASK), registered

Behaviour:
- Reset (rst sampled high at posedge): all outputs 0; all registers 0; FSM to IDLE; idle=1 the following cycle.
- FSM IDLE -> ACTIVE when chip_select && (read || write).
- FSM ACTIVE -> DONE unconditionally. In ACTIVE: decode, perform the access, register rd_data/errors/done.
- FSM DONE -> IDLE when transaction_completed; otherwise hold.
- In DONE only the matching done bit is high; rd_data and errors hold.
- Latency: the request cycle in IDLE is cycle 0; done, data and errors are visible from cycle 2.
- rd_data is 0 for writes and for any erroring read; unused upper bits read 0.
- Register map (R/W legality; a violation gives slave_error, no side effect):
  - 0x00 OUT_DATA RW.
  - 0x04 OUT_SET W: out |= wd. Read gives slave_error.
  - 0x08 OUT_CLR W: out &= ~wd. Read gives slave_error.
  - 0x0C IN_DATA R: debounced inputs. Write gives slave_error.
  - 0x10 RISE_EN RW.
  - 0x14 FALL_EN RW.
  - 0x18 IRQ_STATUS R / W1C.
  - 0x1C IRQ_MASK RW.
  - 0x20 DB_CFG RW, DB_CNT_W bits.
  - Any other addr, or addr[1:0] != 0: decode_error, with done still asserted.
- Debounce:
  - DB_CFG=0: bypass; deb = sync each cycle.
  - Else a shared prescaler wraps every DB_CFG+1 cycles and emits a tick. On a tick, each channel samples sync into smp. deb <= sync only if sync == smp, i.e. the value is stable across two ticks.
  - Prescaler restarts from 0 when DB_CFG is written.
- Edges:
  - rise = deb & ~deb_q; fall = ~deb & deb_q.
  - STATUS[i] sets on (rise & RISE_EN) | (fall & FALL_EN).
  - A hardware set in the same cycle as a W1C of that bit wins (bit stays 1).
- irq updates one cycle after a STATUS or MASK change. Writing MASK never alters STATUS.
- Mid-transaction rst: FSM returns to IDLE and all done/error outputs clear. No partial write is committed after the reset cycle.
- Synchroniser flops are also reset by rst.

Decomposition:
- gpio_v2_pkg holds:
  - register address localparams (OUT_DATA_ADDR .. DB_CFG_ADDR);
  - the slot FSM state enum {IDLE, ACTIVE, DONE} (2-bit);
  - access-type enum.
- Sub-module gpio_debounce (params WIDTH, DB_CNT_W) contains the synchroniser, prescaler, smp/deb registers and the deb_q edge outputs. gpio_v2 holds the slot FSM, register file and irq logic.

Test Plan:
- Reset then write 0x00=0xA, and also 0x04=0x5 and 0x08=0x3 -> out_ports=0xA, then 0xF, then 0xC. wr_done rises in cycle 2 after each request and drops after transaction_completed.
- Read 0x04; write 0x0C; access 0x40; access 0x02 -> slave_error, slave_error, decode_error, decode_error respectively. rd_data=0 and out_ports unchanged throughout.
- DB_CFG=0, in_ports=0x1FF -> read 0x0C returns 0x1FF. DB_CFG=3 and toggle bit0 with 2-cycle glitches -> IN_DATA bit0 never changes. Hold the level for 12 cycles -> bit0 changes.
- RISE_EN=0x1, MASK=0x1, bit0 0->1 -> STATUS=0x1 and irq=1. W1C 0x18=0x1 -> irq=0 the next cycle. A rising edge in the same cycle as the W1C -> STATUS stays 1.
- FALL_EN=0x2, MASK=0 with a bit1 fall -> STATUS=0x2 and irq=0. Then MASK=0x2 -> irq=1.
- rst asserted while in ACTIVE with a write pending to 0x00 -> out_ports=0, idle=1, no done pulse. A subsequent read of 0x00 returns 0.
